// File: rtl/mlp_pkg.sv
// Shared constants and the FSM state type for the MLP result collector.
// Index width is fixed at 4 bits, so NUM_CLASS and NUM_IMG must stay within 1..15.
package mlp_pkg;

  localparam int SCORE_W_DEF   = 24;
  localparam int NUM_CLASS_DEF = 10;
  localparam int NUM_IMG_DEF   = 10;
  localparam int IDX_W         = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/mlp_result_collector_argmax_tracker.sv
// Running signed arg-max over one image's stream of class scores.
// win_idx is the index including the score presented this cycle, so the caller can store the winner on the final beat.
module argmax_tracker
  import mlp_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      en,
  input  logic signed [SCORE_W-1:0] score,
  output logic signed [SCORE_W-1:0] max,
  output logic        [IDX_W-1:0]   idx,
  output logic        [IDX_W-1:0]   win_idx
);

  logic signed [SCORE_W-1:0] max_q, max_d;
  logic        [IDX_W-1:0]   idx_q, idx_d;
  logic        [IDX_W-1:0]   pos_q, pos_d;
  logic                      greater;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      idx_q <= '0;
      pos_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
      pos_q <= pos_d;
    end
  end

  // Strictly-greater update only, so ties keep the lower class number.
  always_comb begin
    max_d   = max_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    greater = score > max_q;
    win_idx = clear ? IDX_W'(1) : (greater ? pos_q : idx_q);
    if (en) begin
      if (clear || greater) max_d = score;
      idx_d = win_idx;
      pos_d = clear ? IDX_W'(2) : pos_q + IDX_W'(1);
    end
  end

  assign max = max_q;
  assign idx = idx_q;

endmodule

// File: rtl/mlp_result_collector.sv
// Collects NUM_CLASS scores per image, emits the arg-max class (1-based) and
// keeps a per-image result buffer for the whole batch.
module mlp_result_collector
  import mlp_pkg::*;
#(
  parameter int SCORE_W   = SCORE_W_DEF,
  parameter int NUM_CLASS = NUM_CLASS_DEF,
  parameter int NUM_IMG   = NUM_IMG_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               score_valid,
  output logic               score_ready,
  input  logic [SCORE_W-1:0] score_data,
  input  logic               score_last,
  output logic               cls_valid,
  input  logic               cls_ready,
  output logic [IDX_W-1:0]   cls_idx,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [IDX_W-1:0]   rd_data,
  output logic               done,
  output logic               err_len
);

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_CLASS - 1);
  localparam logic [IDX_W-1:0] LAST_IMG  = IDX_W'(NUM_IMG - 1);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          beat_q, beat_d;
  logic [IDX_W-1:0]          img_q, img_d;
  logic                      err_q, err_d;
  logic [IDX_W-1:0]          buf_q [NUM_IMG];

  logic                      accept;
  logic                      is_last_beat;
  logic                      start_ok;
  logic [IDX_W-1:0]          win_idx;
  logic [IDX_W-1:0]          trk_idx;
  logic signed [SCORE_W-1:0] max_unused;

  assign accept       = score_valid && score_ready;
  assign is_last_beat = (beat_q == LAST_BEAT);
  assign start_ok     = start && ((state_q == IDLE) || (state_q == DONE));

  argmax_tracker #(
    .SCORE_W (SCORE_W)
  ) u_argmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept && (beat_q == '0)),
    .en      (accept),
    .score   ($signed(score_data)),
    .max     (max_unused),
    .idx     (trk_idx),
    .win_idx (win_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = COLLECT;
      COLLECT: if (accept && is_last_beat) state_d = EMIT;
      EMIT:    if (cls_ready) state_d = (img_q == LAST_IMG) ? DONE : COLLECT;
      DONE:    if (start) state_d = COLLECT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    score_ready = (state_q == COLLECT);
    cls_valid   = (state_q == EMIT);
    done        = (state_q == DONE);
  end

  // The tracker index only moves on accepted beats, so it is stable for the whole EMIT stay.
  assign cls_idx = trk_idx;
  assign err_len = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      img_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      beat_q <= beat_d;
      img_q  <= img_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    beat_d = beat_q;
    img_d  = img_q;
    err_d  = err_q;
    if (start_ok) begin
      beat_d = '0;
      img_d  = '0;
      err_d  = 1'b0;
    end
    if (accept) begin
      beat_d = is_last_beat ? '0 : beat_q + IDX_W'(1);
      if (score_last != is_last_beat) err_d = 1'b1;
    end
    if ((state_q == EMIT) && cls_ready && (img_q != LAST_IMG)) img_d = img_q + IDX_W'(1);
  end

  // Entries survive a new start and are only replaced as each image finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IMG; i++) buf_q[i] <= '0;
    end else if (accept && is_last_beat) begin
      buf_q[img_q] <= win_idx;
    end
  end

  assign rd_data = ({1'b0, rd_addr} < (IDX_W + 1)'(NUM_IMG)) ? buf_q[rd_addr] : '0;

endmodule

// File: doc/mlp_result_collector.md
MLP_RESULT_COLLECTOR -- requirements
Module: mlp_result_collector

Interface
REQ-001 SHALL have parameter SCORE_W, default 24, meaning signed score width from the output layer.
REQ-002 SHALL have parameter NUM_CLASS, default 10, meaning scores per image.
REQ-003 SHALL have parameter NUM_IMG, default 10, meaning images per batch.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  meaning the pulse that begins a batch.
REQ-007 SHALL have port score_valid  input  1  meaning score_data is valid.
REQ-008 SHALL have port score_ready  output  1  meaning the collector accepts a score.
REQ-009 SHALL have port score_data  input  SCORE_W  meaning the signed two's-complement class score.
REQ-010 SHALL have port score_last  input  1  meaning the producer marks the final score of an image.
REQ-011 SHALL have port cls_valid  output  1  meaning cls_idx holds a classification.
REQ-012 SHALL have port cls_ready  input  1  meaning the consumer takes cls_idx.
REQ-013 SHALL have port cls_idx  output  4  meaning the winning class, numbered 1..NUM_CLASS.
REQ-014 SHALL have port rd_addr  input  4  meaning the result buffer read index, 0..NUM_IMG-1.
REQ-015 SHALL have port rd_data  output  4  meaning the stored class for rd_addr.
REQ-016 SHALL have port done  output  1  meaning the batch is complete.
REQ-017 SHALL have port err_len  output  1  meaning a sticky flag for a score_last framing mismatch.

Function
REQ-018 SHALL implement the FSM states IDLE, COLLECT, EMIT and DONE.
REQ-019 SHALL transition IDLE->COLLECT and DONE->COLLECT on start, clearing the image counter, err_len and done; start in COLLECT or EMIT SHALL be ignored.
REQ-020 SHALL drive score_ready=1 only in COLLECT; a beat is accepted when score_valid and score_ready are both 1.
REQ-021 SHALL count accepted beats 0..NUM_CLASS-1 per image; beat 0 loads the running max and the index is set to 1.
REQ-022 SHALL compare later beats as signed values and update on a strictly-greater score only, so that ties keep the lower class index.
REQ-023 SHALL end an image on the NUM_CLASS-th accepted beat regardless of score_last.
REQ-024 SHALL set err_len on an accepted beat whose score_last is 1 before beat NUM_CLASS-1, or is 0 on beat NUM_CLASS-1.
REQ-025 SHALL, on the final beat, write the winning index to buffer[image] and enter EMIT, with cls_valid=1 and cls_idx stable in the following cycle (1-cycle latency).
REQ-026 SHALL hold cls_valid/cls_idx in EMIT until cls_ready; on the handshake it SHALL go to DONE if image==NUM_IMG-1, otherwise increment the image counter and return to COLLECT.
REQ-027 SHALL drive done=1 in DONE, with cls_valid=0 and score_ready=0.
REQ-028 SHALL derive rd_data combinationally from the buffer in every state; rd_addr>=NUM_IMG SHALL return 0.
REQ-029 SHALL retain buffer contents across start; entries are overwritten only as new images complete.

Reset
REQ-030 SHALL, while rst_n=0, force the state to IDLE, score_ready=0, cls_valid=0, cls_idx=0, done=0, err_len=0, all counters to 0 and all buffer entries to 0, asynchronously.
REQ-031 SHALL discard a partially accepted image on reset mid-operation; no buffer write occurs.

Structure
REQ-032 SHALL take NUM_CLASS, NUM_IMG, SCORE_W defaults and the state enum from shared package mlp_pkg.
REQ-033 SHALL place the running max/index compare in sub-module argmax_tracker (inputs: clear, en, score; outputs: max, idx).

Verification
REQ-034 SHALL verify that scores {-5,3,9,2,9,0,-1,4,8,1} with last on beat 10 produce cls_idx=3 one cycle after beat 10, with err_len=0.
REQ-035 SHALL verify that all-negative scores {-9..-1 ascending, -20} produce cls_idx=9.
REQ-036 SHALL verify that score_last on beat 4 gives err_len=1 and that the image still ends at beat 10.
REQ-037 SHALL verify that holding cls_ready=0 for 5 cycles keeps cls_valid and cls_idx stable with score_ready=0 throughout.
REQ-038 SHALL verify that 10 images with winners 1..10 give done=1 and rd_data(addr k)=k+1, and that rd_addr=12 returns 0.
REQ-039 SHALL verify that asserting rst_n=0 after beat 6 of image 2 leaves all outputs at 0 and the buffer cleared, and that a following start reprocesses the batch correctly.
